// File: rtl/func_test_sequencer_pkg.sv
// Shared encodings for the functional-test sequencer: FSM states, command bytes and
// datapath channel indices.
package func_test_sequencer_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CFG    = 4'd1;
    localparam logic [3:0] ST_CTRL   = 4'd2;
    localparam logic [3:0] ST_LOAD   = 4'd3;
    localparam logic [3:0] ST_STOP   = 4'd4;
    localparam logic [3:0] ST_POLL   = 4'd5;
    localparam logic [3:0] ST_DRAIN  = 4'd6;
    localparam logic [3:0] ST_PSTART = 4'd7;
    localparam logic [3:0] ST_PRUN   = 4'd8;
    localparam logic [3:0] ST_PSTOP  = 4'd9;

    localparam logic [7:0] CMD_START_A = 8'hA0;
    localparam logic [7:0] CMD_STOP    = 8'h55;
    localparam logic [7:0] CMD_RDREQ   = 8'h5A;
    localparam logic [7:0] CMD_PER_ON  = 8'hB0;
    localparam logic [7:0] CMD_PER_OFF = 8'hB1;

    localparam logic [2:0] CH_SEL  = 3'd0;
    localparam logic [2:0] CH_CFG  = 3'd2;
    localparam logic [2:0] CH_CTRL = 3'd3;
    localparam logic [2:0] CH_SMP  = 3'd4;

    function automatic logic [4:0] ch_onehot(input logic [2:0] ch);
        logic [4:0] oh;
        oh = '0;
        case (ch)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/func_test_sequencer_byte_tx.sv
// Byte emitter: registers one (channel, byte) request per cycle onto master_data and the
// one-hot valid_bus strobe.
module ft_seq_byte_tx
    import func_test_sequencer_pkg::*;
(
    input  logic       sys_clk,
    input  logic       n_rst,
    input  logic       tx_req,
    input  logic [2:0] tx_ch,
    input  logic [7:0] tx_byte,
    output logic [7:0] master_data,
    output logic [4:0] valid_bus
);

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            master_data <= 8'h00;
            valid_bus   <= 5'b00000;
        end else begin
            master_data <= tx_req ? tx_byte : 8'h00;
            valid_bus   <= tx_req ? ch_onehot(tx_ch) : 5'b00000;
        end
    end

endmodule

// File: rtl/func_test_sequencer.sv
// Host-side sequencer for the functional-testing datapath: configure, load, play, poll, drain.
// Define FT_SEQ_TIMEOUT_EN to add a watchdog that aborts stalled runs after TIMEOUT_CYC cycles.
module func_test_sequencer
    import func_test_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned RETRY_PERIOD = 64,
    parameter int unsigned TIMEOUT_CYC  = 2**20
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             periodic,
    input  logic             stop,
    input  logic             abort,
    input  logic             ccd_mode,
    input  logic             video_sel,
    input  logic [13:0]      black_level,
    input  logic [7:0]       num_reps,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [7:0]       smp_data,
    input  logic             smp_valid,
    output logic             smp_ready,
    output logic [7:0]       master_data,
    output logic [4:0]       valid_bus,
    output logic [4:0]       rdreq_bus,
    input  logic [4:0]       have_msg_bus,
    input  logic [7:0]       slave_data,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned RtW = $clog2(RETRY_PERIOD + 1);

    logic [3:0]       state_q, state_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [CNT_W:0]   bcnt_q, bcnt_d;
    logic [CNT_W:0]   last_idx;
    logic [RtW-1:0]   rt_q, rt_d;
    logic [1:0]       idle_q, idle_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             per_q, mode_q, sel_q;
    logic [13:0]      bl_q;
    logic [7:0]       reps_q;
    logic [CNT_W-1:0] nsmp_q;

    logic             rd_pend_q, rd_valid_q;
    logic [7:0]       rd_data_q;

    logic             tx_req;
    logic [2:0]       tx_ch;
    logic [7:0]       tx_byte;
    logic             start_take, abort_now, timeout, rdreq, have_msg;
    logic [3:0]       unused_have_msg;

    assign have_msg        = have_msg_bus[4];
    assign unused_have_msg = have_msg_bus[3:0];
    assign start_take      = (state_q == ST_IDLE) && start && !abort;
    assign abort_now       = (abort || timeout) && (state_q != ST_IDLE);
    assign last_idx        = {nsmp_q, 1'b0} - 1'b1;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        bcnt_d    = bcnt_q;
        rt_d      = rt_q;
        idle_d    = idle_q;
        err_d     = err_q;
        done_d    = 1'b0;
        tx_req    = 1'b0;
        tx_ch     = CH_CTRL;
        tx_byte   = 8'h00;
        smp_ready = 1'b0;
        rdreq     = 1'b0;

        if (abort_now) begin
            // Leave the datapath in a quiescent state before dropping the run.
            if (state_q == ST_LOAD) begin
                tx_req  = 1'b1;
                tx_byte = CMD_STOP;
            end else if (state_q == ST_PRUN) begin
                tx_req  = 1'b1;
                tx_byte = CMD_PER_OFF;
            end
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_take) begin
                        err_d   = 1'b0;
                        cfg_d   = 2'd0;
                        bcnt_d  = '0;
                        state_d = periodic ? ST_PSTART : ST_CFG;
                    end
                end
                ST_CFG: begin
                    tx_req = 1'b1;
                    tx_ch  = CH_CFG;
                    case (cfg_q)
                        2'd0: begin
                            tx_ch   = CH_SEL;
                            tx_byte = {7'd0, sel_q};
                        end
                        2'd1:    tx_byte = bl_q[7:0];
                        2'd2:    tx_byte = {2'b00, bl_q[13:8]};
                        default: tx_byte = reps_q;
                    endcase
                    cfg_d = cfg_q + 2'd1;
                    if (cfg_q == 2'd3) state_d = ST_CTRL;
                end
                ST_CTRL: begin
                    tx_req  = 1'b1;
                    tx_byte = CMD_START_A | {7'd0, mode_q};
                    state_d = (nsmp_q == '0) ? ST_STOP : ST_LOAD;
                end
                ST_LOAD: begin
                    smp_ready = 1'b1;
                    if (smp_valid) begin
                        tx_req  = 1'b1;
                        tx_ch   = CH_SMP;
                        tx_byte = smp_data;
                        if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == last_idx) state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    tx_req  = 1'b1;
                    tx_byte = CMD_STOP;
                    rt_d    = '0;
                    state_d = ST_POLL;
                end
                ST_POLL: begin
                    if (have_msg) begin
                        idle_d  = 2'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        if (rt_q == '0) begin
                            tx_req  = 1'b1;
                            tx_byte = CMD_RDREQ;
                        end
                        rt_d = (rt_q == RtW'(RETRY_PERIOD - 1)) ? '0 : rt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (have_msg) begin
                        rdreq  = 1'b1;
                        idle_d = 2'd0;
                    end else if (idle_q != 2'd0 && !rd_pend_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (idle_q != 2'd3) begin
                        idle_d = idle_q + 2'd1;
                    end
                end
                ST_PSTART: begin
                    tx_req  = 1'b1;
                    tx_byte = CMD_PER_ON;
                    state_d = ST_PRUN;
                end
                ST_PRUN: begin
                    if (stop) state_d = ST_PSTOP;
                end
                ST_PSTOP: begin
                    tx_req  = 1'b1;
                    tx_byte = CMD_PER_OFF;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef FT_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_arm;

    assign wd_arm  = (state_q == ST_LOAD && !smp_valid) || (state_q == ST_POLL) ||
                     (state_q == ST_PRUN);
    assign timeout = wd_arm && (wd_q >= WdW'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d = wd_q;
        if (!wd_arm || state_d != state_q) begin
            wd_d = '0;
        end else if (wd_q != '1) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            bcnt_q  <= '0;
            rt_q    <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            bcnt_q  <= bcnt_d;
            rt_q    <= rt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            per_q  <= 1'b0;
            mode_q <= 1'b0;
            sel_q  <= 1'b0;
            bl_q   <= '0;
            reps_q <= '0;
            nsmp_q <= '0;
        end else if (start_take) begin
            per_q  <= periodic;
            mode_q <= ccd_mode;
            sel_q  <= video_sel;
            bl_q   <= black_level;
            reps_q <= num_reps;
            nsmp_q <= num_samples;
        end
    end

    // Readback path keeps running across abort so an in-flight byte still reaches the host.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            rd_pend_q  <= rdreq;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) rd_data_q <= slave_data;
        end
    end

    ft_seq_byte_tx u_byte_tx (
        .sys_clk     (sys_clk),
        .n_rst       (n_rst),
        .tx_req      (tx_req),
        .tx_ch       (tx_ch),
        .tx_byte     (tx_byte),
        .master_data (master_data),
        .valid_bus   (valid_bus)
    );

    logic unused_per;
    assign unused_per = per_q;

    assign rdreq_bus = {rdreq, 4'b0000};
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_func_test_sequencer.sv
// Self-checking bench for func_test_sequencer; the watchdog step runs only when
// FT_SEQ_TIMEOUT_EN is defined.
module tb_func_test_sequencer;

    logic        sys_clk = 1'b0;
    logic        n_rst   = 1'b0;
    logic        start = 1'b0, periodic = 1'b0, stop = 1'b0, abort = 1'b0;
    logic        ccd_mode = 1'b0, video_sel = 1'b0;
    logic [13:0] black_level = '0;
    logic [7:0]  num_reps = '0;
    logic [9:0]  num_samples = '0;
    logic [7:0]  smp_data = '0;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [7:0]  master_data;
    logic [4:0]  valid_bus, rdreq_bus;
    logic [4:0]  have_msg_bus = '0;
    logic [7:0]  slave_data = '0;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, done, err;

    func_test_sequencer #(
        .CNT_W        (10),
        .RETRY_PERIOD (64),
        .TIMEOUT_CYC  (1000)
    ) dut (
        .sys_clk      (sys_clk),
        .n_rst        (n_rst),
        .start        (start),
        .periodic     (periodic),
        .stop         (stop),
        .abort        (abort),
        .ccd_mode     (ccd_mode),
        .video_sel    (video_sel),
        .black_level  (black_level),
        .num_reps     (num_reps),
        .num_samples  (num_samples),
        .smp_data     (smp_data),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .master_data  (master_data),
        .valid_bus    (valid_bus),
        .rdreq_bus    (rdreq_bus),
        .have_msg_bus (have_msg_bus),
        .slave_data   (slave_data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_done = 0, onehot_bad = 0;
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    int          t5a_q[$];
    int          t4_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  src_q[$];
    logic [7:0]  rb_q[$];
    logic [7:0]  rb_exp[$];
    int          popped = 0, stall_at = -1, stall_len = 0, stall_rem = 0;
    bit          rb_en = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observe the command channels: {channel, byte} stream with 0x5A retries kept apart.
    always @(negedge sys_clk) begin
        logic [2:0] ch;
        if (n_rst) begin
            if (valid_bus != 5'd0) begin
                ch = 3'd0;
                if ($countones(valid_bus) != 1) onehot_bad++;
                for (int i = 0; i < 5; i++) if (valid_bus[i]) ch = i[2:0];
                if (ch == 3'd3 && master_data == 8'h5A) t5a_q.push_back(cyc);
                else obs_q.push_back({ch, master_data});
                if (ch == 3'd4) t4_q.push_back(cyc);
            end
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) n_done++;
        end
    end

    // Sample source with an optional one-shot stall after a given number of bytes.
    always begin
        logic hs;
        @(negedge sys_clk);
        hs = smp_valid && smp_ready;
        @(posedge sys_clk);
        #1;
        if (hs && src_q.size() > 0) begin
            void'(src_q.pop_front());
            popped++;
            if (popped == stall_at) stall_rem = stall_len;
        end else if (stall_rem > 0) begin
            stall_rem--;
        end
        smp_valid = (src_q.size() > 0) && (stall_rem == 0);
        smp_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end

    // Readback FIFO: data appears on slave_data the cycle after a read request.
    always begin
        logic rq;
        @(negedge sys_clk);
        rq = rdreq_bus[4];
        @(posedge sys_clk);
        #1;
        if (rq && rb_q.size() > 0) slave_data = rb_q.pop_front();
        have_msg_bus = {rb_en && (rb_q.size() > 0), 4'b0000};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        obs_q.delete(); exp_q.delete(); t5a_q.delete(); t4_q.delete(); rd_q.delete();
    endtask

    task automatic setup_src(input int nbytes, input int st_at, input int st_len);
        logic [7:0] b;
        src_q.delete();
        popped = 0; stall_at = st_at; stall_len = st_len; stall_rem = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
        end
    endtask

    task automatic setup_rb(input int nbytes, input bit en);
        logic [7:0] b;
        rb_q.delete(); rb_exp.delete();
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            rb_q.push_back(b);
            rb_exp.push_back(b);
        end
        rb_en = en;
    endtask

    task automatic push_hdr(input logic sel, input logic [13:0] bl, input logic [7:0] reps,
                            input logic mode);
        exp_q.push_back({3'd0, 7'd0, sel});
        exp_q.push_back({3'd2, bl[7:0]});
        exp_q.push_back({3'd2, 2'b00, bl[13:8]});
        exp_q.push_back({3'd2, reps});
        exp_q.push_back({3'd3, 8'hA0 | {7'd0, mode}});
    endtask

    // Pulse start, then scramble the fields to show they were latched.
    task automatic kick(input logic per, input logic mode, input logic sel,
                        input logic [13:0] bl, input logic [7:0] reps, input logic [9:0] ns);
        periodic = per; ccd_mode = mode; video_sel = sel;
        black_level = bl; num_reps = reps; num_samples = ns;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        periodic = ~per; ccd_mode = ~mode; video_sel = ~sel;
        black_level = ~bl; num_reps = ~reps; num_samples = ~ns;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n0;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (n_done > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
    endtask

    task automatic cmp_rd(input string tag);
        chk({tag, "_rdlen"}, rd_q.size(), rb_exp.size());
        for (int i = 0; i < rb_exp.size() && i < rd_q.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), {24'd0, rd_q[i]}, {24'd0, rb_exp[i]});
    endtask

    initial begin
        bit          ok;
        int          n0, t0, t_err;
        logic [13:0] bl;
        logic [7:0]  reps;
        logic        sel, mode;

        tick(3);
        n_rst = 1'b1;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, err, rd_valid, smp_ready, rdreq_bus, valid_bus, master_data,
                         rd_data}, 0);

        // Single capture with the reference field values.
        clear_logs();
        setup_src(6, -1, 0);
        setup_rb(4, 1'b0);
        push_hdr(1'b0, 14'h1234, 8'd8, 1'b0);
        foreach (src_q[i]) exp_q.push_back({3'd4, src_q[i]});
        exp_q.push_back({3'd3, 8'h55});
        n0 = n_done;
        kick(1'b0, 1'b0, 1'b0, 14'h1234, 8'd8, 10'd3);
        chk("run1_busy", busy, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (t5a_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("run1_poll", ok, 1);
        tick(200);
        rb_en = 1'b1;
        wait_done(400, ok);
        chk("run1_done", ok, 1);
        tick(3);
        chk("run1_done_once", n_done - n0, 1);
        cmp_stream("run1");
        chk("run1_n5a", t5a_q.size(), 4);
        for (int i = 1; i < t5a_q.size(); i++)
            chk($sformatf("run1_retry%0d", i), t5a_q[i] - t5a_q[i-1], 64);
        cmp_rd("run1");
        chk("run1_idle", {busy, err}, 0);
        rb_en = 1'b0;

        // Source stall after byte 2; readback already pending so no retry is sent.
        clear_logs();
        bl = 14'($urandom); reps = 8'($urandom); sel = 1'b1; mode = 1'b1;
        setup_src(8, 2, 10);
        setup_rb(2, 1'b1);
        push_hdr(sel, bl, reps, mode);
        foreach (src_q[i]) exp_q.push_back({3'd4, src_q[i]});
        exp_q.push_back({3'd3, 8'h55});
        tick(2);
        kick(1'b0, mode, sel, bl, reps, 10'd4);
        wait_done(300, ok);
        chk("stall_done", ok, 1);
        tick(3);
        cmp_stream("stall");
        chk("stall_gap", (t4_q.size() >= 3) ? t4_q[2] - t4_q[1] : -1, 11);
        chk("stall_n5a", t5a_q.size(), 0);
        cmp_rd("stall");
        rb_en = 1'b0;

        // No samples: CTRL goes straight to the stop byte.
        clear_logs();
        bl = 14'($urandom); reps = 8'($urandom); sel = 1'($urandom); mode = 1'b1;
        setup_src(4, -1, 0);
        setup_rb(1, 1'b1);
        push_hdr(sel, bl, reps, mode);
        exp_q.push_back({3'd3, 8'h55});
        tick(2);
        kick(1'b0, mode, sel, bl, reps, 10'd0);
        wait_done(200, ok);
        chk("nosmp_done", ok, 1);
        tick(3);
        cmp_stream("nosmp");
        chk("nosmp_ch4", t4_q.size(), 0);
        cmp_rd("nosmp");
        rb_en = 1'b0;
        src_q.delete();

        // Periodic playback.
        clear_logs();
        exp_q.push_back({3'd3, 8'hB0});
        exp_q.push_back({3'd3, 8'hB1});
        tick(2);
        kick(1'b1, 1'($urandom), 1'($urandom), 14'($urandom), 8'($urandom), 10'($urandom));
        tick(3);
        chk("per_busy", busy, 1);
        tick(500);
        chk("per_still_busy", busy, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(20, ok);
        chk("per_done", ok, 1);
        tick(2);
        cmp_stream("per");
        chk("per_idle", {busy, err}, 0);

        // Abort in LOAD after two bytes, then the next start clears err.
        clear_logs();
        bl = 14'($urandom); reps = 8'($urandom); sel = 1'($urandom); mode = 1'($urandom);
        setup_src(10, 2, 5000);
        push_hdr(sel, bl, reps, mode);
        exp_q.push_back({3'd4, src_q[0]});
        exp_q.push_back({3'd4, src_q[1]});
        exp_q.push_back({3'd3, 8'h55});
        tick(2);
        n0 = n_done;
        kick(1'b0, mode, sel, bl, reps, 10'd5);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (t4_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_reach", ok, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        chk("abort_nodone", n_done - n0, 0);
        cmp_stream("abort");
        src_q.delete();
        stall_rem = 0;
        tick(2);
        kick(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 10'd0);
        tick(1);
        chk("restart_err", err, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(20, ok);
        chk("restart_done", ok, 1);

        // Asynchronous reset in the middle of a drain.
        clear_logs();
        setup_rb(30, 1'b1);
        tick(2);
        kick(1'b0, 1'b0, 1'b0, 14'($urandom), 8'($urandom), 10'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (rd_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_reach", ok, 1);
        #3;
        n_rst = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_outs", {done, err, rd_valid, smp_ready, rdreq_bus, valid_bus, master_data,
                            rd_data}, 0);
        rb_en = 1'b0;
        rb_q.delete();
        tick(2);
        n_rst = 1'b1;
        tick(2);
        chk("rstmid_after", {busy, valid_bus}, 0);

`ifdef FT_SEQ_TIMEOUT_EN
        // Watchdog: readback never arrives.
        clear_logs();
        setup_rb(0, 1'b0);
        kick(1'b0, 1'b0, 1'b0, 14'($urandom), 8'($urandom), 10'd0);
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (t5a_q.size() > 0) begin
                ok = 1'b1;
                t0 = t5a_q[0];
                break;
            end
        end
        chk("wd_poll", ok, 1);
        ok = 1'b0;
        t_err = 0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            if (err) begin
                ok = 1'b1;
                t_err = cyc;
                break;
            end
        end
        chk("wd_err", ok, 1);
        chk("wd_latency", t_err - t0, 999);
        chk("wd_busy", busy, 0);
`endif

        chk("onehot", onehot_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
